// File: rtl/mdu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: op encodings, FSM state, default latencies.
// Macro MDU_MADD_EN makes the multiply-accumulate codes 6-9 part of the multiply class.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int MDU_DEF_MUL_CYCLES = 5;
  localparam int MDU_DEF_DIV_CYCLES = 10;
  localparam int MDU_CNT_W          = 5;

  function automatic logic mdu_is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic mdu_is_mul(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
           (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

  function automatic logic mdu_is_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

`ifdef MDU_MADD_EN
  function automatic logic mdu_is_acc(input logic [3:0] op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic mdu_is_sub(input logic [3:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction
`endif

endpackage

// File: rtl/mdu_multicycle.sv
// Multi-cycle HI/LO multiply/divide unit: behavioural arithmetic, latency set purely by a down-counter.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MDU_MADD_EN.
module mdu_multicycle
  import mdu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = MDU_DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = MDU_DEF_DIV_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cancel,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int W2 = 2 * XLEN;
  localparam logic [MDU_CNT_W-1:0] CNT_ONE  = MDU_CNT_W'(1);
  localparam logic [MDU_CNT_W-1:0] CNT_MUL  = MDU_CNT_W'(MUL_CYCLES);
  localparam logic [MDU_CNT_W-1:0] CNT_DIV  = MDU_CNT_W'(DIV_CYCLES);
  localparam logic [XLEN-1:0]      X_ONE    = {{(XLEN-1){1'b0}}, 1'b1};

  mdu_state_e           state_q, state_d;
  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]           op_q, op_d;
  logic [XLEN-1:0]      a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]      hi_q, hi_d, lo_q, lo_d;

  logic                 signed_s, a_neg_s, b_neg_s, div_zero_s;
  logic [W2-1:0]        a_ext_s, b_ext_s, prod_s, mul_res_s;
  logic [XLEN-1:0]      a_mag_s, b_mag_s, divisor_s, q_mag_s, r_mag_s, quot_s, rem_s;

  // Result datapath, evaluated from the operands and HI/LO captured at launch.
  always_comb begin
    signed_s = mdu_is_signed(op_q);
    a_ext_s  = {{XLEN{signed_s & a_q[XLEN-1]}}, a_q};
    b_ext_s  = {{XLEN{signed_s & b_q[XLEN-1]}}, b_q};
    // Low 2*XLEN bits of the extended product equal the signed or unsigned full product.
    prod_s   = a_ext_s * b_ext_s;
`ifdef MDU_MADD_EN
    mul_res_s = !mdu_is_acc(op_q) ? prod_s :
                mdu_is_sub(op_q)  ? ({hi_q, lo_q} - prod_s) : ({hi_q, lo_q} + prod_s);
`else
    mul_res_s = prod_s;
`endif
    a_neg_s    = signed_s & a_q[XLEN-1];
    b_neg_s    = signed_s & b_q[XLEN-1];
    a_mag_s    = a_neg_s ? ('0 - a_q) : a_q;
    b_mag_s    = b_neg_s ? ('0 - b_q) : b_q;
    div_zero_s = (b_q == '0);
    // Substitute divisor keeps the divider free of X when the result is discarded anyway.
    divisor_s  = div_zero_s ? X_ONE : b_mag_s;
    q_mag_s    = a_mag_s / divisor_s;
    r_mag_s    = a_mag_s % divisor_s;
    quot_s     = (a_neg_s ^ b_neg_s) ? ('0 - q_mag_s) : q_mag_s;
    rem_s      = a_neg_s ? ('0 - r_mag_s) : r_mag_s;
  end

  // Next-state logic: launch, count down, retire or cancel.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !cancel) begin
          if (mdu_is_mul(op)) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_MUL;
            op_d    = op;
            a_d     = a;
            b_d     = b;
          end else if (mdu_is_div(op)) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_DIV;
            op_d    = op;
            a_d     = a;
            b_d     = b;
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cancel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (mdu_is_div(op_q)) begin
            if (!div_zero_s) begin
              hi_d = rem_s;
              lo_d = quot_s;
            end else begin
              hi_d = hi_q;
              lo_d = lo_q;
            end
          end else begin
            hi_d = mul_res_s[W2-1:XLEN];
            lo_d = mul_res_s[XLEN-1:0];
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and architectural register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
